// File: rtl/regfile_pkg.sv
// Shared definitions for the 4x8 register file and its command front-end.
// Holds the default widths, the command-byte field positions as
// width-parameterised helpers, and the controller FSM state encoding.
package regfile_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 2;

    // Command byte layout: [data_w-1] op, [data_w-2:addr_w] reserved, [addr_w-1:0] addr
    function automatic int op_bit(input int data_w);
        return data_w - 1;
    endfunction

    function automatic int rsv_hi(input int data_w);
        return data_w - 2;
    endfunction

    function automatic int rsv_lo(input int addr_w);
        return addr_w;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GET_DATA  = 3'd1,
        ST_WRITE     = 3'd2,
        ST_READ      = 3'd3,
        ST_READ_WAIT = 3'd4,
        ST_RESP      = 3'd5
    } ctrl_state_t;

endpackage

// File: rtl/regfile_cmd_ctrl.sv
// Command front-end for the register file.
// Accepts command/data bytes over a valid/ready input, strobes the register
// file for writes and reads, and returns read data over a valid/ready port.
//
// Ports:
//   clk, rst           clock (rising edge), async active-high reset
//   in_valid/in_ready  input byte handshake, in_data carries the byte
//   rf_w_en, rf_r_en   register-file strobes, decoded from state only
//   rf_addr, rf_wdata  held address / write data towards the file
//   rf_rdata           registered read data from the file
//   rsp_valid/ready    read response handshake, rsp_data carries the byte
//   err                one-cycle pulse when a malformed command is dropped
//   busy               controller is not idle
//
// state        | meaning
// -------------+----------------------------------------------
// ST_IDLE      | waiting for a command byte
// ST_GET_DATA  | write accepted, waiting for the data byte
// ST_WRITE     | one-cycle write strobe to the file
// ST_READ      | one-cycle read strobe to the file
// ST_READ_WAIT | file read data valid, captured into rsp_data
// ST_RESP      | response presented until the consumer takes it
module regfile_cmd_ctrl
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              rf_w_en,
    output logic              rf_r_en,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              err,
    output logic              busy
);

    localparam int OP_POS = op_bit(DATA_W);
    localparam int RSV_H  = rsv_hi(DATA_W);
    localparam int RSV_L  = rsv_lo(ADDR_W);

    ctrl_state_t state, state_nxt;
    logic        load_cmd;
    logic        load_data;
    logic        bad_cmd;
    logic        rsv_nonzero;

    assign rsv_nonzero = |in_data[RSV_H:RSV_L];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            rf_addr  <= '0;
            rf_wdata <= '0;
            rsp_data <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_nxt;
            err   <= bad_cmd;
            if (load_cmd)
                rf_addr <= in_data[ADDR_W-1:0];
            if (load_data)
                rf_wdata <= in_data;
            if (state == ST_READ_WAIT)
                rsp_data <= rf_rdata;
        end
    end

    always_comb begin
        state_nxt = state;
        load_cmd  = 1'b0;
        load_data = 1'b0;
        bad_cmd   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    // Malformed commands are dropped whole: address is not disturbed.
                    if (rsv_nonzero) begin
                        bad_cmd = 1'b1;
                    end else begin
                        load_cmd  = 1'b1;
                        state_nxt = in_data[OP_POS] ? ST_GET_DATA : ST_READ;
                    end
                end
            end
            ST_GET_DATA: begin
                if (in_valid) begin
                    load_data = 1'b1;
                    state_nxt = ST_WRITE;
                end
            end
            ST_WRITE:     state_nxt = ST_IDLE;
            ST_READ:      state_nxt = ST_READ_WAIT;
            ST_READ_WAIT: state_nxt = ST_RESP;
            ST_RESP:      if (rsp_ready) state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    // in_ready is gated by rst so nothing is offered while reset is held.
    assign in_ready  = !rst && (state == ST_IDLE || state == ST_GET_DATA);
    assign rf_w_en   = (state == ST_WRITE);
    assign rf_r_en   = (state == ST_READ);
    assign rsp_valid = (state == ST_RESP);
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_regfile_cmd_ctrl.sv
module tb_regfile_cmd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       rf_w_en;
    logic       rf_r_en;
    logic [1:0] rf_addr;
    logic [7:0] rf_wdata;
    logic [7:0] rf_rdata = 8'h00;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       err;
    logic       busy;

    always #5 clk = ~clk;

    regfile_cmd_ctrl #(.DATA_W(8), .ADDR_W(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .rf_w_en(rf_w_en), .rf_r_en(rf_r_en), .rf_addr(rf_addr),
        .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .err(err), .busy(busy)
    );

    // Register file attached to the controller: storage survives controller reset.
    logic [7:0] rf_mem [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    always @(posedge clk) begin
        if (rf_w_en) rf_mem[rf_addr] <= rf_wdata;
        if (rf_r_en) rf_rdata <= rf_mem[rf_addr];
    end

    // Transaction-level model: what the file should contain and what must come out.
    logic [7:0] shadow [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    logic [9:0] exp_w [$];
    logic [7:0] exp_r [$];
    logic [7:0] rsp_log [$];
    int         exp_err = 0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model.
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            chk("strobe_excl", {31'b0, rf_w_en & rf_r_en}, 32'd0);
            if (rf_w_en) begin
                chk("write_expected", {31'b0, exp_w.size() != 0}, 32'd1);
                if (exp_w.size() != 0)
                    chk("write_addr_data", {22'b0, rf_addr, rf_wdata}, {22'b0, exp_w.pop_front()});
            end
            if (err) begin
                chk("err_expected", {31'b0, exp_err > 0}, 32'd1);
                if (exp_err > 0) exp_err--;
            end
            if (prev_valid && !prev_ready) begin
                chk("rsp_hold_valid", {31'b0, rsp_valid}, 32'd1);
                chk("rsp_hold_data", {24'b0, rsp_data}, {24'b0, prev_data});
            end
            if (rsp_valid && rsp_ready) begin
                chk("rsp_expected", {31'b0, exp_r.size() != 0}, 32'd1);
                if (exp_r.size() != 0)
                    chk("rsp_data", {24'b0, rsp_data}, {24'b0, exp_r.pop_front()});
                rsp_log.push_back(rsp_data);
            end
            prev_valid = rsp_valid;
            prev_ready = rsp_ready;
            prev_data  = rsp_data;
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        bit hs = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 50 && !hs; i++) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
        end
        if (!hs) chk("accept_timeout", 32'd0, 32'd1);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [7:0] d);
        exp_w.push_back({a, d});
        shadow[a] = d;
        send_byte(8'h80 | {6'b0, a});
        send_byte(d);
    endtask

    task automatic do_read(input logic [1:0] a);
        exp_r.push_back(shadow[a]);
        send_byte({6'b0, a});
    endtask

    task automatic do_bad(input logic [7:0] b);
        exp_err++;
        send_byte(b);
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int i = 0; i < 100 && !idle; i++) begin
            @(negedge clk);
            idle = !busy;
        end
        if (!idle) chk("idle_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; rsp_ready = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_outs", {19'b0, rf_w_en, rf_r_en, rf_addr, rsp_valid, err, busy, rsp_data},
            32'd0);
        chk("rst_wdata", {24'b0, rf_wdata}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // 1. Write 0x5A to addr 2, read it back with latency checks
        do_write(2'd2, 8'h5A);
        @(negedge clk);
        chk("t1_wr", {21'b0, rf_w_en, rf_addr, rf_wdata}, {21'b0, 1'b1, 2'd2, 8'h5A});
        @(negedge clk);
        chk("t1_wr_once", {31'b0, rf_w_en}, 32'd0);
        @(posedge clk); #1;
        do_read(2'd2);
        @(negedge clk);
        chk("t1_r_en_c1", {30'b0, rf_r_en, in_ready}, 32'b10);
        @(negedge clk);
        chk("t1_noresp_c2", {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("t1_resp_c3", {23'b0, rsp_valid, rsp_data}, {23'b0, 1'b1, 8'h5A});
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_idle_c4", {30'b0, busy, in_ready}, 32'b01);
        @(posedge clk); #1;

        // 2. Malformed command
        do_bad(8'h10);
        @(negedge clk);
        chk("t2_err", {28'b0, err, in_ready, rf_w_en, rf_r_en}, 32'b1100);
        @(negedge clk);
        chk("t2_err_once", {29'b0, err, busy, in_ready}, 32'b001);
        @(posedge clk); #1;

        // 6. All addresses, reads back-to-back
        for (int i = 0; i < 4; i++) do_write(i[1:0], 8'h11 * (i + 1));
        for (int i = 0; i < 4; i++) do_read(i[1:0]);
        wait_idle();
        chk("t6_log_size", rsp_log.size(), 32'd5);
        for (int i = 0; i < 4; i++)
            if (rsp_log.size() == 5)
                chk("t6_readback", {24'b0, rsp_log[i + 1]}, 32'h11 * (i + 1));

        // 3. Response backpressure on addr 1
        rsp_ready = 1'b0;
        do_read(2'd1);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_hold", {22'b0, rsp_valid, in_ready, rsp_data}, {22'b0, 2'b10, 8'h22});
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t3_released", {29'b0, busy, in_ready, rsp_valid}, 32'b010);
        @(posedge clk); #1;

        // 4. Input stall between command and data
        exp_w.push_back({2'd3, 8'hC3});
        shadow[3] = 8'hC3;
        send_byte(8'h83);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_stall", {29'b0, rf_w_en, in_ready, busy}, 32'b011);
        end
        @(posedge clk); #1;
        send_byte(8'hC3);
        @(negedge clk);
        chk("t4_wr", {21'b0, rf_w_en, rf_addr, rf_wdata}, {21'b0, 1'b1, 2'd3, 8'hC3});
        @(posedge clk); #1;

        // 5. Reset in GET_DATA: the write must be abandoned
        send_byte(8'h83);
        in_valid = 1'b1; in_data = 8'h99;
        @(negedge clk);
        chk("t5_in_get_data", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_rst_outs", {18'b0, in_ready, rf_w_en, rf_r_en, rf_addr, rsp_valid, err, busy,
            rsp_data}, 32'd0);
        chk("t5_rst_wdata", {24'b0, rf_wdata}, 32'd0);
        @(posedge clk); #1 rst = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_no_write", {30'b0, rf_w_en, in_ready}, 32'b01);
        end
        @(posedge clk); #1;
        do_read(2'd3);
        wait_idle();
        if (rsp_log.size() != 0)
            chk("t5_old_value", {24'b0, rsp_log[rsp_log.size() - 1]}, 32'hC3);

        chk("end_w_drained", exp_w.size(), 32'd0);
        chk("end_r_drained", exp_r.size(), 32'd0);
        chk("end_err_drained", exp_err, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
